// File: rtl/hc_csr_bank_if.sv
// hc_csr_bank_if: MMIO link between the CCI-P shim and the CSR bank.
//   rx_mmio_channel : c0 MMIO request (hdr.address is a dword index, hdr.tid,
//                     512-bit data, mmioWrValid, mmioRdValid)
//   tx_mmio_channel : c2 MMIO read response (hdr.tid, mmioRdValid, 64-bit data)
// Modports: master = shim side (drives requests), slave = CSR bank.
interface hc_csr_bank_if;
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                mmioWrValid;
    logic                mmioRdValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  t_if_ccip_c0_Rx rx_mmio_channel;
  t_if_ccip_c2_Tx tx_mmio_channel;

  modport master (output rx_mmio_channel, input tx_mmio_channel);
  modport slave  (input rx_mmio_channel, output tx_mmio_channel);
endinterface

// File: rtl/hc_csr_bank.sv
// hc_csr_bank: MMIO CSR bank holding the DSM base, the run-control FSM and
// NUM_BUFFERS address/size descriptors; answers MMIO reads one cycle later.
// Ports:
//   clk, SoftReset (async, active high)
//   mmio        : slave side of hc_csr_bank_if (c0 requests in, c2 responses out)
//   user_done   : user logic finished, moves RUN -> STOP
//   dsm_base    : DSM base address
//   buf_addr/buf_size/buf_valid : descriptor i at [64*i +: 64] / [SIZE_W*i +: SIZE_W] / [i]
//   user_reset, start_pulse, running, stop_pulse : run control to user logic
// Optional feature macro: HC_CSR_WRITE_LOCK_EN -- descriptor/DSM writes in RUN
// are discarded and counted in a saturating lock_err field (status[47:40]).
module hc_csr_bank #(
  parameter int unsigned NUM_BUFFERS = 4,
  parameter logic [15:0] BASE_ADDR   = 16'h120,
  parameter logic [15:0] DSM_ADDR    = 16'h110,
  parameter logic [15:0] CTRL_ADDR   = 16'h118,
  parameter logic [15:0] STATUS_ADDR = 16'h108,
  parameter int unsigned SIZE_W      = 32,
  parameter logic [15:0] MMIO_LIMIT  = 16'h400
) (
  input  logic                          clk,
  input  logic                          SoftReset,
  hc_csr_bank_if.slave                  mmio,
  input  logic                          user_done,
  output logic [63:0]                   dsm_base,
  output logic [NUM_BUFFERS*64-1:0]     buf_addr,
  output logic [NUM_BUFFERS*SIZE_W-1:0] buf_size,
  output logic [NUM_BUFFERS-1:0]        buf_valid,
  output logic                          user_reset,
  output logic                          start_pulse,
  output logic                          running,
  output logic                          stop_pulse
);
  typedef enum logic [2:0] {
    S_CSR_RESET = 3'd0,
    S_CSR_IDLE  = 3'd1,
    S_CSR_RUN   = 3'd2,
    S_CSR_STOP  = 3'd3
  } state_e;

  localparam logic [15:0] BASE_DW = BASE_ADDR >> 2;
  localparam logic [15:0] DSM_DW  = DSM_ADDR >> 2;
  localparam logic [15:0] CTRL_DW = CTRL_ADDR >> 2;
  localparam logic [15:0] STAT_DW = STATUS_ADDR >> 2;

  logic [15:0] addr;
  logic [63:0] wdata;
  logic        wr_vld, rd_vld;
  assign addr   = mmio.rx_mmio_channel.hdr.address;
  assign wdata  = mmio.rx_mmio_channel.data[63:0];
  assign wr_vld = mmio.rx_mmio_channel.mmioWrValid;
  assign rd_vld = mmio.rx_mmio_channel.mmioRdValid;

  logic unused_ok;
  assign unused_ok = ^{mmio.rx_mmio_channel.data[511:64],
                       mmio.rx_mmio_channel.hdr.length, mmio.rx_mmio_channel.hdr.rsvd};

  // ---- decode ----
  logic        in_range, dsm_hit, ctrl_hit, stat_hit, desc_hit, size_sel;
  logic [15:0] desc_idx;
  always_comb begin
    in_range = {addr, 2'b00} < {2'b00, MMIO_LIMIT};
    desc_idx = 16'((addr - BASE_DW) >> 2);
    desc_hit = in_range && (addr >= BASE_DW) && (32'(desc_idx) < NUM_BUFFERS);
    size_sel = addr[1];
    dsm_hit  = in_range && (addr == DSM_DW);
    ctrl_hit = in_range && (addr == CTRL_DW);
    stat_hit = in_range && (addr == STAT_DW);
  end

  // ---- state ----
  state_e                              state_q, state_d;
  logic [63:0]                         dsm_q, dsm_d;
  logic [31:0]                         ctrl_q, ctrl_d;
  logic [NUM_BUFFERS-1:0][63:0]        addr_q, addr_d;
  logic [NUM_BUFFERS-1:0][SIZE_W-1:0]  size_q, size_d;
  logic [NUM_BUFFERS-1:0]              aseen_q, aseen_d, sseen_q, sseen_d;
  logic [7:0]                          lock_err_q, lock_err_d;
  logic user_reset_q, user_reset_d, running_q, running_d;
  logic start_q, start_d, stop_q, stop_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [8:0]  rsp_tid_q, rsp_tid_d;
  logic [63:0] rsp_data_q, rsp_data_d;

  logic        wr_en, wr_blk, ctrl_wr;
  logic [31:0] ctrl_val;
  logic [63:0] status, rd_data;

  always_comb begin
    dsm_d = dsm_q; addr_d = addr_q; size_d = size_q; ctrl_d = ctrl_q;
    aseen_d = aseen_q; sseen_d = sseen_q; lock_err_d = lock_err_q;
    wr_en = wr_vld && (dsm_hit || desc_hit);
`ifdef HC_CSR_WRITE_LOCK_EN
    // requestors are consuming the descriptors; refuse changes under them
    wr_blk = (state_q == S_CSR_RUN);
`else
    wr_blk = 1'b0;
`endif
    if (wr_en && wr_blk) begin
      wr_en = 1'b0;
      if (lock_err_q != 8'hFF) lock_err_d = lock_err_q + 8'd1;
    end
    if (wr_en && dsm_hit) dsm_d = wdata;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (wr_en && desc_hit && desc_idx == 16'(i)) begin
        if (size_sel) begin size_d[i] = wdata[SIZE_W-1:0]; sseen_d[i] = 1'b1; end
        else          begin addr_d[i] = wdata;             aseen_d[i] = 1'b1; end
      end
    end

    // run control; a control write takes priority over user_done
    ctrl_wr  = wr_vld && ctrl_hit;
    ctrl_val = wdata[31:0];
    state_d = state_q; start_d = 1'b0; stop_d = 1'b0;
    if (ctrl_wr) begin
      ctrl_d = ctrl_val;
      case (ctrl_val)
        32'h0: state_d = S_CSR_RESET;
        32'h1: if (state_q == S_CSR_RESET) state_d = S_CSR_IDLE;
        32'h3: if (state_q == S_CSR_IDLE || state_q == S_CSR_STOP) begin
                 state_d = S_CSR_RUN; start_d = 1'b1;
               end
        32'h7: if (state_q == S_CSR_RUN) begin state_d = S_CSR_STOP; stop_d = 1'b1; end
        default: ;
      endcase
      // descriptors must be re-armed after a reset, contents are kept
      if (ctrl_val == 32'h0) begin aseen_d = '0; sseen_d = '0; lock_err_d = '0; end
    end else if (state_q == S_CSR_RUN && user_done) begin
      state_d = S_CSR_STOP; stop_d = 1'b1;
    end
    user_reset_d = (state_d == S_CSR_RESET);
    running_d    = (state_d == S_CSR_RUN);
  end

  // ---- read path ----
  always_comb begin
    status  = {16'h0, lock_err_q, 4'h0, 32'(buf_valid), user_done, state_q};
    rd_data = '0;
    if (stat_hit)      rd_data = status;
    else if (ctrl_hit) rd_data = {32'h0, ctrl_q};
    else if (dsm_hit)  rd_data = dsm_q;
    else begin
      for (int i = 0; i < NUM_BUFFERS; i++)
        if (desc_hit && desc_idx == 16'(i))
          rd_data = size_sel ? 64'(size_q[i]) : addr_q[i];
    end
    // simultaneous write and read: the read is dropped
    rsp_vld_d  = rd_vld && !wr_vld && (stat_hit || ctrl_hit || dsm_hit || desc_hit);
    rsp_tid_d  = rsp_vld_d ? mmio.rx_mmio_channel.hdr.tid : 9'h0;
    rsp_data_d = rsp_vld_d ? rd_data : 64'h0;
  end

  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      state_q <= S_CSR_RESET; dsm_q <= '0; ctrl_q <= '0;
      addr_q <= '0; size_q <= '0; aseen_q <= '0; sseen_q <= '0; lock_err_q <= '0;
      user_reset_q <= 1'b1; running_q <= 1'b0; start_q <= 1'b0; stop_q <= 1'b0;
      rsp_vld_q <= 1'b0; rsp_tid_q <= '0; rsp_data_q <= '0;
    end else begin
      state_q <= state_d; dsm_q <= dsm_d; ctrl_q <= ctrl_d;
      addr_q <= addr_d; size_q <= size_d; aseen_q <= aseen_d; sseen_q <= sseen_d;
      lock_err_q <= lock_err_d;
      user_reset_q <= user_reset_d; running_q <= running_d;
      start_q <= start_d; stop_q <= stop_d;
      rsp_vld_q <= rsp_vld_d; rsp_tid_q <= rsp_tid_d; rsp_data_q <= rsp_data_d;
    end
  end

  assign dsm_base    = dsm_q;
  assign buf_addr    = addr_q;
  assign buf_size    = size_q;
  assign buf_valid   = aseen_q & sseen_q;
  assign user_reset  = user_reset_q;
  assign running     = running_q;
  assign start_pulse = start_q;
  assign stop_pulse  = stop_q;
  assign mmio.tx_mmio_channel = {rsp_tid_q, rsp_vld_q, rsp_data_q};
endmodule

// File: tb/tb_hc_csr_bank.sv
// Self-checking bench for hc_csr_bank: byte-address level model plus directed
// vectors with hand-computed expectations.
module tb_hc_csr_bank;
  localparam int NB = 4;
`ifdef HC_CSR_WRITE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0, SoftReset = 1'b0, user_done = 1'b0;
  logic [63:0]      dsm_base;
  logic [NB*64-1:0] buf_addr;
  logic [NB*32-1:0] buf_size;
  logic [NB-1:0]    buf_valid;
  logic user_reset, start_pulse, running, stop_pulse;

  hc_csr_bank_if bus();

  hc_csr_bank #(.NUM_BUFFERS(NB)) dut (
    .clk(clk), .SoftReset(SoftReset), .mmio(bus), .user_done(user_done),
    .dsm_base(dsm_base), .buf_addr(buf_addr), .buf_size(buf_size), .buf_valid(buf_valid),
    .user_reset(user_reset), .start_pulse(start_pulse), .running(running),
    .stop_pulse(stop_pulse));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- model: registers by byte address, state as 0..3 ----
  logic [63:0] m_addr [NB];
  logic [31:0] m_size [NB];
  bit          m_aseen [NB], m_sseen [NB];
  int          m_state, m_lock;
  logic [63:0] m_dsm, m_rdata;
  logic [31:0] m_ctrl;
  logic [8:0]  m_rtid;
  bit          m_start, m_stop, m_rv;

  function automatic logic [NB-1:0] m_valid();
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = m_aseen[i] & m_sseen[i];
    return v;
  endfunction

  always @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      m_state <= 0; m_lock <= 0; m_dsm <= 0; m_ctrl <= 0; m_rdata <= 0; m_rtid <= 0;
      m_start <= 0; m_stop <= 0; m_rv <= 0;
      for (int i = 0; i < NB; i++) begin
        m_addr[i] <= 0; m_size[i] <= 0; m_aseen[i] <= 0; m_sseen[i] <= 0;
      end
    end else begin
      automatic int          ba = int'(bus.rx_mmio_channel.hdr.address) * 4;
      automatic bit          wr = bus.rx_mmio_channel.mmioWrValid;
      automatic bit          rd = bus.rx_mmio_channel.mmioRdValid;
      automatic logic [63:0] d  = bus.rx_mmio_channel.data[63:0];
      automatic bit          ok = ba < 'h400;
      automatic bit          is_desc = ok && ba >= 'h120 && (ba - 'h120) / 16 < NB;
      automatic int          di = (ba - 'h120) / 16;
      automatic bit          is_size = ((ba - 'h120) % 16) >= 8;
      m_start <= 0; m_stop <= 0; m_rv <= 0; m_rdata <= 0; m_rtid <= 0;
      if (wr && ok && (ba == 'h110 || is_desc)) begin
        if (LOCK && m_state == 2) m_lock <= (m_lock == 255) ? 255 : m_lock + 1;
        else if (ba == 'h110) m_dsm <= d;
        else if (is_size) begin m_size[di] <= d[31:0]; m_sseen[di] <= 1; end
        else begin m_addr[di] <= d; m_aseen[di] <= 1; end
      end
      if (rd && !wr && ok && (ba == 'h108 || ba == 'h110 || ba == 'h118 || is_desc)) begin
        m_rv <= 1; m_rtid <= bus.rx_mmio_channel.hdr.tid;
        if (ba == 'h108)
          m_rdata <= 64'(m_state) | (64'(user_done) << 3) | (64'(m_valid()) << 4) | (64'(m_lock) << 40);
        else if (ba == 'h110) m_rdata <= m_dsm;
        else if (ba == 'h118) m_rdata <= 64'(m_ctrl);
        else m_rdata <= is_size ? 64'(m_size[di]) : m_addr[di];
      end
      if (wr && ok && ba == 'h118) begin
        m_ctrl <= d[31:0];
        case (d[31:0])
          32'h0: begin
            m_state <= 0; m_lock <= 0;
            for (int i = 0; i < NB; i++) begin m_aseen[i] <= 0; m_sseen[i] <= 0; end
          end
          32'h1: if (m_state == 0) m_state <= 1;
          32'h3: if (m_state == 1 || m_state == 3) begin m_state <= 2; m_start <= 1; end
          32'h7: if (m_state == 2) begin m_state <= 3; m_stop <= 1; end
          default: ;
        endcase
      end else if (m_state == 2 && user_done) begin
        m_state <= 3; m_stop <= 1;
      end
    end
  end

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    if (!SoftReset) begin
      chk("user_reset", user_reset, m_state == 0);
      chk("running", running, m_state == 2);
      chk("start_pulse", start_pulse, m_start);
      chk("stop_pulse", stop_pulse, m_stop);
      chk("dsm_base", dsm_base, m_dsm);
      for (int i = 0; i < NB; i++) begin
        chk($sformatf("buf_addr[%0d]", i), buf_addr[64*i +: 64], m_addr[i]);
        chk($sformatf("buf_size[%0d]", i), buf_size[32*i +: 32], m_size[i]);
      end
      chk("buf_valid", buf_valid, m_valid());
      chk("rsp_valid", bus.tx_mmio_channel.mmioRdValid, m_rv);
      if (m_rv) begin
        chk("rsp_tid", bus.tx_mmio_channel.hdr.tid, m_rtid);
        chk("rsp_data", bus.tx_mmio_channel.data, m_rdata);
      end
    end
  end

  // ---- stimulus ----
  task automatic drive(input bit wr, input bit rd, input logic [15:0] ba,
                       input logic [63:0] d, input logic [8:0] tid);
    @(negedge clk);
    bus.rx_mmio_channel.hdr.address = {2'b00, ba[15:2]};
    bus.rx_mmio_channel.hdr.tid     = tid;
    bus.rx_mmio_channel.data        = {448'h0, d};
    bus.rx_mmio_channel.mmioWrValid = wr;
    bus.rx_mmio_channel.mmioRdValid = rd;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.rx_mmio_channel.mmioWrValid = 1'b0;
    bus.rx_mmio_channel.mmioRdValid = 1'b0;
  endtask

  task automatic chk_rsp(input string nm, input logic [8:0] tid, input logic [63:0] d);
    chk({nm, "_vld"}, bus.tx_mmio_channel.mmioRdValid, 1'b1);
    chk({nm, "_tid"}, bus.tx_mmio_channel.hdr.tid, tid);
    chk({nm, "_data"}, bus.tx_mmio_channel.data, d);
  endtask

  initial begin
    bus.rx_mmio_channel = '0;
    #2 SoftReset = 1'b1;              // mid-cycle, before the first edge
    #1;
    chk("rst_user_reset", user_reset, 1'b1);
    chk("rst_outs", {running, start_pulse, stop_pulse, buf_valid}, '0);
    chk("rst_dsm", dsm_base, 64'h0);
    chk("rst_addr", buf_addr[127:0], '0);
    chk("rst_rsp", bus.tx_mmio_channel.mmioRdValid, 1'b0);
    repeat (2) @(negedge clk);
    SoftReset = 1'b0;

    drive(0, 1, 16'h108, 64'h0, 9'd3); idle(); #1;
    chk_rsp("status_rst", 9'd3, 64'h0);

    // descriptor 1
    drive(1, 0, 16'h130, 64'hDEAD_BEEF_0000_1000, 9'd0);
    drive(1, 0, 16'h138, 64'h40, 9'd0);
    idle(); #1;
    chk("d1_addr", buf_addr[127:64], 64'hDEAD_BEEF_0000_1000);
    chk("d1_size", buf_size[63:32], 64'h40);
    chk("d1_valid", buf_valid, 4'b0010);
    drive(0, 1, 16'h138, 64'h0, 9'd5); idle(); #1;
    chk_rsp("rd138", 9'd5, 64'h40);
    @(negedge clk); #1;
    chk("rd138_single", bus.tx_mmio_channel.mmioRdValid, 1'b0);
    // back-to-back reads
    drive(0, 1, 16'h130, 64'h0, 9'd1);
    drive(0, 1, 16'h138, 64'h0, 9'd2); #1;
    chk_rsp("b2b_a", 9'd1, 64'hDEAD_BEEF_0000_1000);
    idle(); #1;
    chk_rsp("b2b_b", 9'd2, 64'h40);

    // control sequence
    drive(1, 0, 16'h118, 64'h1, 9'd0); idle(); #1;
    chk("idle_user_reset", user_reset, 1'b0);
    drive(1, 0, 16'h118, 64'h3, 9'd0); idle(); #1;
    chk("start_hi", {start_pulse, running}, 2'b11);
    @(negedge clk); #1;
    chk("start_once", {start_pulse, running}, 2'b01);
    @(negedge clk); user_done = 1'b1;
    @(negedge clk); #1;
    chk("stop_hi", {stop_pulse, running}, 2'b10);
    user_done = 1'b0;
    drive(0, 1, 16'h108, 64'h0, 9'd7); idle(); #1;
    chk("status_stop", bus.tx_mmio_channel.data[2:0], 3'd3);
    chk_rsp("status_stop", 9'd7, 64'h23);

    // restart, then reset from RUN
    drive(1, 0, 16'h118, 64'h3, 9'd0); idle(); #1;
    chk("restart_run", running, 1'b1);
    drive(1, 0, 16'h118, 64'h0, 9'd0); idle(); #1;
    chk("rst0_user_reset", user_reset, 1'b1);
    chk("rst0_valid", buf_valid, 4'b0000);
    chk("rst0_kept", buf_addr[127:64], 64'hDEAD_BEEF_0000_1000);
    drive(1, 0, 16'h118, 64'h1, 9'd0);
    drive(1, 0, 16'h118, 64'h5, 9'd0);
    drive(0, 1, 16'h108, 64'h0, 9'd8); idle(); #1;
    chk_rsp("status_idle", 9'd8, 64'h1);

    // undecoded accesses and write+read collision
    drive(1, 0, 16'h160, 64'h55, 9'd0);
    drive(0, 1, 16'h400, 64'h0, 9'd9); idle(); #1;
    chk("rd400_none", bus.tx_mmio_channel.mmioRdValid, 1'b0);
    chk("w160_none", buf_valid, 4'b0000);
    drive(0, 1, 16'h160, 64'h0, 9'd9); idle(); #1;
    chk("rd160_none", bus.tx_mmio_channel.mmioRdValid, 1'b0);
    drive(1, 1, 16'h110, 64'hCAFE, 9'd4); idle(); #1;
    chk("wr_rd_norsp", bus.tx_mmio_channel.mmioRdValid, 1'b0);
    chk("wr_rd_dsm", dsm_base, 64'hCAFE);

    // writes while running
    drive(1, 0, 16'h118, 64'h3, 9'd0);
    repeat (3) drive(1, 0, 16'h120, 64'h1111, 9'd0);
    drive(0, 1, 16'h108, 64'h0, 9'd10); idle(); #1;
    chk("run_state", bus.tx_mmio_channel.data[2:0], 3'd2);
    if (LOCK) begin
      chk("lock_addr0", buf_addr[63:0], 64'h0);
      chk("lock_cnt", bus.tx_mmio_channel.data[47:40], 8'd3);
    end else begin
      chk("nolock_addr0", buf_addr[63:0], 64'h1111);
      chk("nolock_cnt", bus.tx_mmio_channel.data[47:40], 8'd0);
    end

    // reset with a response in flight
    drive(0, 1, 16'h110, 64'h0, 9'd6);
    @(posedge clk); #2;
    chk("pend_vld", bus.tx_mmio_channel.mmioRdValid, 1'b1);
    SoftReset = 1'b1; #1;
    chk("pend_cleared", bus.tx_mmio_channel.mmioRdValid, 1'b0);
    chk("pend_outs", {user_reset, running, buf_valid}, 6'b100000);
    chk("pend_dsm", dsm_base, 64'h0);
    bus.rx_mmio_channel.mmioRdValid = 1'b0;
    repeat (2) @(negedge clk);
    SoftReset = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hc_csr_bank.md
Name: hc_csr_bank

Overview:
- Parametrised MMIO CSR bank for HardCloud.
- Decodes CCI-P c0 MMIO writes into:
  - the DSM base register,
  - a control state machine,
  - NUM_BUFFERS address/size buffer descriptors.
- Also answers MMIO reads of those registers on the c2 channel.
- Sits between the CCI-P shim and the requestor/user logic; supplies descriptors and run control to the read/write requestors.

Parameters:
- NUM_BUFFERS, 4, number of buffer descriptors (1..32).
- BASE_ADDR, 16'h120, byte address of descriptor 0; descriptor i address register at BASE_ADDR+16*i, size register at BASE_ADDR+16*i+8.
- DSM_ADDR, 16'h110, byte address of the DSM base register.
- CTRL_ADDR, 16'h118, byte address of the control register.
- STATUS_ADDR, 16'h108, byte address of the read-only status register.
- SIZE_W, 32, width of each size field.
- MMIO_LIMIT, 16'h400, byte address limit; accesses at or above it are ignored.

Ports:
- clk  in  1  clock
- SoftReset  in  1  asynchronous active-high reset
- rx_mmio_channel  in  t_if_ccip_c0_Rx  MMIO requests (hdr, data, mmioWrValid, mmioRdValid)
- tx_mmio_channel  out  t_if_ccip_c2_Tx  MMIO read response (hdr.tid, mmioRdValid, data)
- user_done  in  1  user logic finished; sampled in RUN
- dsm_base  out  64  DSM base address
- buf_addr  out  NUM_BUFFERS*64  descriptor addresses, descriptor i at [64*i +: 64]
- buf_size  out  NUM_BUFFERS*SIZE_W  descriptor sizes
- buf_valid  out  NUM_BUFFERS  descriptor i has had both address and size written since the last reset
- user_reset  out  1  reset to user logic
- start_pulse  out  1  one-cycle pulse on entry to RUN
- running  out  1  high in RUN
- stop_pulse  out  1  one-cycle pulse on entry to STOP

Behaviour:
- Reset values:
  - all registers, buf_valid, start_pulse, stop_pulse, running and tx_mmio_channel.mmioRdValid = 0.
  - user_reset = 1; state = S_CSR_RESET.
- Address decode:
  - hdr.address is a dword index; register X decodes at X>>2.
  - Only accesses with byte address < MMIO_LIMIT decode.
  - Descriptor index i = (addr - BASE_ADDR>>2) >> 2; addr[1] selects size (1) or address (0).
  - Decode hits only for i < NUM_BUFFERS.
- Writes:
  - Take effect one cycle after mmioWrValid.
  - Address registers take data[63:0]; size registers take data[SIZE_W-1:0].
  - A write to address sets an internal addr_seen[i]; a write to size sets size_seen[i].
  - buf_valid[i] = addr_seen[i] & size_seen[i].
  - A writes to undecoded addresses are dropped.
- Control state machine (driven by writes of data[31:0] to CTRL_ADDR):
  - S_CSR_RESET: user_reset=1. Value 32'h1 -> S_CSR_IDLE.
  - S_CSR_IDLE: user_reset=0. Value 32'h3 -> S_CSR_RUN, start_pulse for 1 cycle.
  - S_CSR_RUN: running=1. Value 32'h7, or user_done=1 -> S_CSR_STOP, stop_pulse for 1 cycle.
  - S_CSR_STOP: holds. Value 32'h3 -> S_CSR_RUN (restart).
  - From any state, value 32'h0 -> S_CSR_RESET, which also clears addr_seen/size_seen (register contents kept).
  - Other values: no transition.
  - Control write and user_done in the same cycle: the control write wins.
- Status register (read-only):
  - bits[2:0] = state encoding (RESET=0, IDLE=1, RUN=2, STOP=3).
  - bit[3] = user_done; bits[35:4] = buf_valid zero-extended.
- Reads:
  - A decoded mmioRdValid gives a response exactly 1 cycle later: mmioRdValid=1, hdr.tid echoed, data = register value (size zero-extended to 64).
  - Undecoded reads get no response; another block owns them.
  - Back-to-back reads give back-to-back responses.
  - A write and read in the same cycle is a protocol violation: the write is processed and the read is dropped.
- Reset asserted mid-operation clears everything asynchronously, including any pending read response.

Optional Feature:
- HC_CSR_WRITE_LOCK_EN defined:
  - Descriptor and DSM writes received in S_CSR_RUN are discarded.
  - Each discarded write increments an 8-bit saturating lock_err counter, readable at status bits[47:40].
  - The counter clears on entry to S_CSR_RESET.
- Undefined: writes take effect in any state; status bits[47:40] read 0.

Test Plan:
- Reset with SoftReset=1 mid-cycle -> all outputs 0, user_reset=1, status read = 64'h0.
- Write 64'hDEAD_BEEF_0000_1000 to byte 0x130 (desc 1 address) and 32'h40 to 0x138 -> buf_addr[1] matches, buf_size[1]=0x40, buf_valid=4'b0010; read 0x138 with tid=5 -> response next cycle, tid 5, data 0x40.
- Control writes 1, 3 -> user_reset drops, then start_pulse for exactly 1 cycle, running=1; then user_done=1 -> stop_pulse, status[2:0]=3.
- Write 0 in RUN -> S_CSR_RESET, buf_valid=0, buf_addr[1] retained; write 0x5 in IDLE -> no transition.
- Write to 0x120+16*NUM_BUFFERS and read 0x400 -> no register change, no read response.
- With HC_CSR_WRITE_LOCK_EN, in RUN, write 0x120 three times -> buf_addr[0] unchanged, status[47:40]=3; without the macro -> buf_addr[0] updated.
